block_decompressor: RTL
=======================

# block_decompressor

Stream decompressor: the receive-side counterpart of the team's eight-word compressor. Accepts the packed compressed AXI-stream (256-bit beats, byte-granular `tkeep`, `tlast` per frame) and unpacks variable-length records into full 8×32-bit blocks. Sits between the DMA read stream and the consumer of uncompressed data, using the same `wrt_en` global-enable convention as the rest of the datapath.

## Interface
- `DATA_WIDTH`, 32: bits per uncompressed word.
- `NUM_DATA`, 8: words per block; one record = one block.
- `TAG_WIDTH`, 2: tag bits per word.
- `BUF_BYTES`, 96: byte capacity of the realignment buffer.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `wrt_en`  in  1  global enable; 0 freezes all state.
- `data_in`  in  256  compressed beat, byte 0 = bits [7:0].
- `tkeep_in`  in  32  valid bytes; contiguous from byte 0; all ones except on the `tlast_in` beat.
- `tvalid_in`  in  1  input beat valid.
- `tlast_in`  in  1  last beat of frame.
- `tready_out`  out  1  input ready.
- `data_out`  out  256  decompressed block, word i = bits [32i+31:32i].
- `tvalid_out`  out  1  output valid.
- `tlast_out`  out  1  block is the last of its frame.
- `tready_in`  in  1  downstream ready.
- `err`  out  1  sticky malformed-frame flag.

## Operation
- Record format: 16-bit tag field (little-endian; word i tag at bits [2i+1:2i]), then payloads for words 0..7 in order, little-endian bytes. Tags: 00 → 0x00000000, 0 bytes; 01 → sign-extended byte, 1 byte; 10 → sign-extended halfword, 2 bytes; 11 → full word, 4 bytes. Record length L = 2 + Σ payload bytes, range 2..34. Records pack back-to-back across beats.
- Buffer: `BUF_BYTES` bytes plus 7-bit `count`; byte 0 is oldest.
- Accept: `tready_out` = `wrt_en` & (`count` ≤ 64) & !`last_pending`. On handshake, popcount(`tkeep_in`) bytes are appended at offset `count` − consumed-this-cycle. If `tlast_in`, set `last_pending`.
- Decode (combinational from buffer): `count` ≥ 2 → parse tags, compute L; record ready when `count` ≥ L.
- Emit: record ready, `wrt_en`=1 and (output register empty or `tready_in`=1) → expand into output register, `tvalid_out`←1, shift buffer by L. `tlast_out` = `last_pending` & (L == `count`); clears `last_pending`.
- Malformed: `last_pending` & `count`>0 & (`count`<2 or `count`<L) → `err`←1, `count`←0, `last_pending`←0, no output. `err` clears only on reset.
- `wrt_en`=0: no accept, no emit, outputs held.

## Timing
- Reset values: `tvalid_out`=0, `tlast_out`=0, `data_out`=0, `err`=0, `tready_out`=0 during reset; `count`=0, `last_pending`=0.
- Latency: beat sampled at edge t → first record in it presented after edge t+1 (if L bytes available).
- Throughput: one record per cycle; simultaneous accept and emit in the same cycle is required.
- Output held stable while `tvalid_out`=1 and `tready_in`=0.
- `count` ≤ 64 at accept guarantees progress: any `count` < 34 admits a beat; no deadlock.
- Reset mid-frame: all buffered bytes and pending output discarded immediately.

## Structure
- Shared package: tag encodings, `TAG_ZERO/BYTE/HALF/WORD`, record min/max lengths, `BUF_BYTES`.
- One sub-module: `record_expander` (combinational: 34-byte window → L and 256-bit block), reused by verification as reference model.

## Test plan
- Full record: tag 0xFFFF + 32 payload bytes, beat0 `tkeep`=0xFFFFFFFF, beat1 `tkeep`=0x00000003 `tlast` → one block equal to payload words, `tlast_out`=1.
- Zero record: bytes 00 00, `tkeep`=0x3, `tlast` → data_out all zero, `tlast_out`=1.
- Mixed: tag 0x00E4, payload 80 | FF 7F | EF BE AD DE (9 bytes) → words 0x00000000, 0xFFFFFF80, 0x00007FFF, 0xDEADBEEF, rest 0.
- Backpressure: 20 full records, `tready_in` low 10 cycles → `tready_out` drops at `count`>64, all 20 blocks in order, no duplicates.
- Malformed: frame ends with 1 spare byte → `err`=1, no extra block; following valid frame decodes correctly.
- Reset mid-frame: `reset`=0 after beat0 of full record → outputs zero; new frame afterwards decodes correctly.

Source files
------------

// File: rtl/block_decompressor_pkg.sv
// Shared definitions for the block decompressor: record tag encodings, lengths and buffer sizing.
package block_decompressor_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned NUM_DATA    = 8;
  localparam int unsigned TAG_WIDTH   = 2;
  localparam int unsigned BUF_BYTES   = 96;
  localparam int unsigned BEAT_BYTES  = 32;
  localparam int unsigned BLOCK_WIDTH = DATA_WIDTH * NUM_DATA;
  localparam int unsigned REC_MIN_LEN = 2;
  localparam int unsigned REC_MAX_LEN = 34;
  // Highest fill level at which a full beat still fits.
  localparam int unsigned ACCEPT_MAX  = BUF_BYTES - BEAT_BYTES;

  typedef enum logic [TAG_WIDTH-1:0] {
    TAG_ZERO = 2'b00,
    TAG_BYTE = 2'b01,
    TAG_HALF = 2'b10,
    TAG_WORD = 2'b11
  } tag_e;

  function automatic logic [2:0] payload_len(tag_e tag);
    case (tag)
      TAG_BYTE: return 3'd1;
      TAG_HALF: return 3'd2;
      TAG_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/block_decompressor_if.sv
// Compressed-in / block-out stream bundle for the block decompressor.
interface block_decompressor_if;
  import block_decompressor_pkg::*;

  logic [BLOCK_WIDTH-1:0] data_in;
  logic [BEAT_BYTES-1:0]  tkeep_in;
  logic                   tvalid_in;
  logic                   tlast_in;
  logic                   tready_out;
  logic [BLOCK_WIDTH-1:0] data_out;
  logic                   tvalid_out;
  logic                   tlast_out;
  logic                   tready_in;
  logic                   err;

  modport slave (
    input  data_in, tkeep_in, tvalid_in, tlast_in, tready_in,
    output tready_out, data_out, tvalid_out, tlast_out, err
  );

  modport master (
    output data_in, tkeep_in, tvalid_in, tlast_in, tready_in,
    input  tready_out, data_out, tvalid_out, tlast_out, err
  );

endinterface

// File: rtl/block_decompressor_record_expander.sv
// Combinational record decoder: parses the tag field of a 34-byte window, returns the record
// length and the expanded 8-word block.
module record_expander
  import block_decompressor_pkg::*;
(
  input  logic [REC_MAX_LEN*8-1:0] window_i,
  output logic [5:0]               rec_len_o,
  output logic [BLOCK_WIDTH-1:0]   block_o
);

  always_comb begin
    logic [(REC_MAX_LEN+4)*8-1:0] padded;
    logic [5:0]                   off;
    logic [DATA_WIDTH-1:0]        raw;
    tag_e                         tag;
    // Zero pad so a read at the tail of a short record never leaves the vector.
    padded  = {32'b0, window_i};
    off     = 6'(REC_MIN_LEN);
    raw     = '0;
    tag     = TAG_ZERO;
    block_o = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      tag = tag_e'(window_i[TAG_WIDTH*i +: TAG_WIDTH]);
      raw = padded[off*8 +: DATA_WIDTH];
      unique case (tag)
        TAG_ZERO: block_o[DATA_WIDTH*i +: DATA_WIDTH] = '0;
        TAG_BYTE: block_o[DATA_WIDTH*i +: DATA_WIDTH] = {{24{raw[7]}}, raw[7:0]};
        TAG_HALF: block_o[DATA_WIDTH*i +: DATA_WIDTH] = {{16{raw[15]}}, raw[15:0]};
        TAG_WORD: block_o[DATA_WIDTH*i +: DATA_WIDTH] = raw;
      endcase
      off = off + 6'(payload_len(tag));
    end
    rec_len_o = off;
  end

endmodule

// File: rtl/block_decompressor.sv
// Stream decompressor: realigns packed compressed beats in a byte buffer and emits one
// expanded 8-word block per record.
module block_decompressor
  import block_decompressor_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  input logic                 wrt_en,
  block_decompressor_if.slave bus
);

  localparam int unsigned BufW = BUF_BYTES * 8;

  logic [BufW-1:0]        buf_q, buf_d;
  logic [6:0]             count_q, count_d;
  logic                   last_pending_q, last_pending_d;
  logic [BLOCK_WIDTH-1:0] data_out_q;
  logic                   tvalid_out_q, tlast_out_q, err_q;

  logic [5:0]             rec_len;
  logic [BLOCK_WIDTH-1:0] block;
  logic [5:0]             in_bytes;
  logic [BLOCK_WIDTH-1:0] masked;
  logic [6:0]             consumed, base;
  logic                   rec_ready, emit, accept, malformed, is_last_rec;

  record_expander u_expander (
    .window_i  (buf_q[REC_MAX_LEN*8-1:0]),
    .rec_len_o (rec_len),
    .block_o   (block)
  );

  // Held low during reset so nothing is accepted into a buffer that is being cleared.
  assign bus.tready_out = reset & wrt_en & (count_q <= 7'(ACCEPT_MAX)) & ~last_pending_q;

  always_comb begin
    in_bytes = '0;
    masked   = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      in_bytes = in_bytes + 6'(bus.tkeep_in[j]);
      if (bus.tkeep_in[j]) masked[8*j +: 8] = bus.data_in[8*j +: 8];
    end
  end

  assign rec_ready   = (count_q >= 7'(REC_MIN_LEN)) && (count_q >= {1'b0, rec_len});
  assign emit        = wrt_en && rec_ready && (!tvalid_out_q || bus.tready_in);
  assign accept      = bus.tvalid_in && bus.tready_out;
  // Once the frame's last beat is in, an incomplete record can never complete.
  assign malformed   = wrt_en && last_pending_q && (count_q != '0) && !rec_ready;
  assign is_last_rec = last_pending_q && (count_q == {1'b0, rec_len});
  assign consumed    = emit ? {1'b0, rec_len} : '0;
  assign base        = count_q - consumed;

  always_comb begin
    buf_d          = buf_q;
    count_d        = count_q;
    last_pending_d = last_pending_q;
    if (malformed) begin
      buf_d          = '0;
      count_d        = '0;
      last_pending_d = 1'b0;
    end else begin
      // Bytes above count stay zero, so the shifted-in beat can simply be OR-ed in.
      buf_d   = (buf_q >> {consumed, 3'b000}) |
                (accept ? ({{(BufW-BLOCK_WIDTH){1'b0}}, masked} << {base, 3'b000}) : '0);
      count_d = base + (accept ? {1'b0, in_bytes} : 7'd0);
      if ((emit && is_last_rec) || (last_pending_q && count_q == '0)) last_pending_d = 1'b0;
      if (accept && bus.tlast_in) last_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q          <= '0;
      count_q        <= '0;
      last_pending_q <= 1'b0;
      data_out_q     <= '0;
      tvalid_out_q   <= 1'b0;
      tlast_out_q    <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      count_q        <= count_d;
      last_pending_q <= last_pending_d;
      if (emit) begin
        data_out_q   <= block;
        tvalid_out_q <= 1'b1;
        tlast_out_q  <= is_last_rec;
      end else if (wrt_en && bus.tready_in) begin
        tvalid_out_q <= 1'b0;
      end
      if (malformed) err_q <= 1'b1;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.tvalid_out = tvalid_out_q;
  assign bus.tlast_out  = tlast_out_q;
  assign bus.err        = err_q;

endmodule
